// File: rtl/bf_skid.sv
// Elastic 32-bit skid buffer: valid/ready on both sides, one skid slot so that
// IN_READY depends only on registered state, plus a saturating stall counter.
module bf_skid #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    input  logic             FLUSH,
    output logic [1:0]       OCC,
    output logic [CNT_W-1:0] STALL_CNT
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               in_ready_s;
    logic               out_valid_s;
    logic               push_s;
    logic               pop_s;

    assign in_ready_s  = (state_q != FULL);
    assign out_valid_s = (state_q != EMPTY);
    assign push_s      = IN_VALID & in_ready_s;
    assign pop_s       = out_valid_s & OUT_READY;

    // Next-state, data and stall-counter computation.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        if (out_valid_s && !OUT_READY && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_d = stall_q;
        end

        // Flush wins; held data is left in place, only validity is dropped.
        if (FLUSH) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push_s) begin
                        out_d   = IN;
                        state_d = ONE;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (push_s && pop_s) begin
                        out_d   = IN;
                        state_d = ONE;
                    end else if (push_s) begin
                        skid_d  = IN;
                        state_d = FULL;
                    end else if (pop_s) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = ONE;
                    end
                end
                FULL: begin
                    if (pop_s) begin
                        out_d   = skid_q;
                        state_d = ONE;
                    end else begin
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State, data and counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= EMPTY;
            out_q   <= {WIDTH{1'b0}};
            skid_q  <= {WIDTH{1'b0}};
            stall_q <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    assign IN_READY  = in_ready_s;
    assign OUT_VALID = out_valid_s;
    assign OUT       = out_q;
    assign OCC       = state_q;
    assign STALL_CNT = stall_q;

endmodule

// File: tb/tb_bf_skid.sv
// Directed bench for bf_skid: a two-entry FIFO model checked every cycle, plus
// hand-computed literal expectations for each scenario.
module tb_bf_skid;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] IN = 32'd0;
    logic        IN_VALID = 1'b0;
    logic        OUT_READY = 1'b0;
    logic        FLUSH = 1'b0;

    logic        in_ready;
    logic [31:0] out_w;
    logic        out_valid;
    logic [1:0]  occ;
    logic [15:0] stall16;

    logic        s_in_ready;
    logic [31:0] s_out;
    logic        s_out_valid;
    logic [1:0]  s_occ;
    logic [3:0]  stall4;

    int checks = 0;
    int failures = 0;

    bf_skid u_dut (
        .CLK(CLK), .RST(RST), .IN(IN), .IN_VALID(IN_VALID), .IN_READY(in_ready),
        .OUT(out_w), .OUT_VALID(out_valid), .OUT_READY(OUT_READY), .FLUSH(FLUSH),
        .OCC(occ), .STALL_CNT(stall16)
    );

    bf_skid #(.WIDTH(32), .CNT_W(4)) u_sat (
        .CLK(CLK), .RST(RST), .IN(IN), .IN_VALID(IN_VALID), .IN_READY(s_in_ready),
        .OUT(s_out), .OUT_VALID(s_out_valid), .OUT_READY(OUT_READY), .FLUSH(FLUSH),
        .OCC(s_occ), .STALL_CNT(stall4)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: list of held words (oldest first) and ideal stall counts.
    logic [31:0] mq [2];
    logic [31:0] nq [2];
    logic [1:0]  m_occ;
    logic [1:0]  n_occ;
    logic [15:0] m_st16;
    logic [3:0]  m_st4;
    logic        m_push;
    logic        m_pop;

    assign m_push = IN_VALID && (m_occ < 2'd2);
    assign m_pop  = (m_occ != 2'd0) && OUT_READY;

    always_comb begin
        nq    = mq;
        n_occ = m_occ;
        if (m_pop) begin
            nq[0] = mq[1];
            n_occ = m_occ - 2'd1;
        end
        if (m_push) begin
            nq[n_occ[0]] = IN;
            n_occ = n_occ + 2'd1;
        end
    end

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_occ  <= 2'd0;
            mq[0]  <= 32'd0;
            mq[1]  <= 32'd0;
            m_st16 <= 16'd0;
            m_st4  <= 4'd0;
        end else begin
            if (m_occ != 2'd0 && !OUT_READY) begin
                if (m_st16 != 16'hFFFF) m_st16 <= m_st16 + 16'd1;
                if (m_st4 != 4'hF) m_st4 <= m_st4 + 4'd1;
            end
            if (FLUSH) begin
                m_occ <= 2'd0;
            end else begin
                m_occ <= n_occ;
                mq    <= nq;
            end
        end
    end

    always @(negedge CLK) begin
        chk("m_in_ready", {31'd0, in_ready}, {31'd0, (m_occ != 2'd2)});
        chk("m_out_valid", {31'd0, out_valid}, {31'd0, (m_occ != 2'd0)});
        chk("m_occ", {30'd0, occ}, {30'd0, m_occ});
        chk("m_stall16", {16'd0, stall16}, {16'd0, m_st16});
        chk("m_stall4", {28'd0, stall4}, {28'd0, m_st4});
        chk("m_sat_occ", {30'd0, s_occ}, {30'd0, m_occ});
        chk("m_sat_in_ready", {31'd0, s_in_ready}, {31'd0, (m_occ != 2'd2)});
        chk("m_sat_out_valid", {31'd0, s_out_valid}, {31'd0, (m_occ != 2'd0)});
        if (m_occ != 2'd0) begin
            chk("m_out", out_w, mq[0]);
            chk("m_sat_out", s_out, mq[0]);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] words [5];

    initial begin
        words[0] = 32'd1;
        words[1] = 32'd2;
        words[2] = 32'd15;
        words[3] = 32'hF0F0F0F0;
        words[4] = 32'hAAAAAAAA;

        tick();
        tick();
        RST = 1'b0;
        chk("rst_occ", {30'd0, occ}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out", out_w, 32'd0);
        chk("rst_stall", {16'd0, stall16}, 32'd0);

        // Full-throughput stream.
        OUT_READY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            IN = words[i];
            IN_VALID = 1'b1;
            tick();
            chk("stream_out", out_w, words[i]);
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_occ", {30'd0, occ}, 32'd1);
        end
        IN_VALID = 1'b0;
        tick();
        chk("stream_end_occ", {30'd0, occ}, 32'd0);
        chk("stream_stall", {16'd0, stall16}, 32'd0);

        // Backpressure fill.
        OUT_READY = 1'b0;
        IN = 32'd1; IN_VALID = 1'b1;
        tick();
        chk("bp_occ1", {30'd0, occ}, 32'd1);
        IN = 32'd2;
        tick();
        chk("bp_occ2", {30'd0, occ}, 32'd2);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_out", out_w, 32'd1);
        IN = 32'd15;
        tick();
        chk("bp_hold_occ", {30'd0, occ}, 32'd2);
        chk("bp_hold_out", out_w, 32'd1);
        chk("bp_stall", {16'd0, stall16}, 32'd2);

        // Drain; 15 is only taken once IN_READY returns.
        OUT_READY = 1'b1;
        tick();
        chk("drain_out2", out_w, 32'd2);
        chk("drain_occ1", {30'd0, occ}, 32'd1);
        chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("drain_out15", out_w, 32'd15);
        IN_VALID = 1'b0;
        tick();
        chk("drain_occ0", {30'd0, occ}, 32'd0);
        chk("drain_stall", {16'd0, stall16}, 32'd2);

        // Flush from FULL with IN_VALID asserted.
        OUT_READY = 1'b0;
        IN = 32'hF0F0F0F0; IN_VALID = 1'b1;
        tick();
        IN = 32'hAAAAAAAA;
        tick();
        chk("fl_occ2", {30'd0, occ}, 32'd2);
        FLUSH = 1'b1; IN = 32'd15;
        tick();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        chk("fl_occ", {30'd0, occ}, 32'd0);
        chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
        chk("fl_stall", {16'd0, stall16}, 32'd4);
        OUT_READY = 1'b1;
        tick();
        tick();
        chk("fl_no_15", {31'd0, out_valid}, 32'd0);

        // Flush from ONE with a simultaneous push and pop: pushed word discarded.
        IN = 32'd7; IN_VALID = 1'b1;
        tick();
        chk("fl1_occ1", {30'd0, occ}, 32'd1);
        FLUSH = 1'b1; IN = 32'd9;
        tick();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        tick();
        chk("fl1_occ0", {30'd0, occ}, 32'd0);

        // Async reset between edges while FULL.
        OUT_READY = 1'b0;
        IN = 32'd3; IN_VALID = 1'b1;
        tick();
        IN = 32'd4;
        tick();
        IN_VALID = 1'b0;
        chk("ar_occ2", {30'd0, occ}, 32'd2);
        #2;
        RST = 1'b1;
        #1;
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_out", out_w, 32'd0);
        chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
        chk("ar_occ", {30'd0, occ}, 32'd0);
        chk("ar_stall", {16'd0, stall16}, 32'd0);
        tick();
        RST = 1'b0;

        // Stall counter saturation on the CNT_W=4 instance.
        IN = 32'd5; IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 15) chk("sat_at15", {28'd0, stall4}, 32'd15);
        end
        chk("sat_stall4", {28'd0, stall4}, 32'd15);
        chk("sat_stall16", {16'd0, stall16}, 32'd20);
        chk("sat_out", out_w, 32'd5);

        OUT_READY = 1'b1;
        tick();
        chk("final_occ", {30'd0, occ}, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
